// File: rtl/imem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, imem_arbiter and the single-port RAM.
// master = CPU core plus RAM side, slave = the arbiter.
interface imem_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [31:0]           i_rdata;
    logic                  i_err;

    logic                  d_req;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [31:0]           d_addr;
    logic [31:0]           d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    logic                  d_err;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch/data arbiter for one single-port RAM: D-over-I priority with an I starvation guard.
// IMEM_ARB_MISALIGN_CHK_EN: misaligned requests are granted but answered with err, no RAM access.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_STALL  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_arbiter_if.slave bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_DRD  = 2'd2;
    localparam logic [1:0] OWN_DWR  = 2'd3;

    logic                  ready_q;
    logic [3:0]            stall_cnt_q, stall_cnt_d;
    logic [1:0]            owner_q, owner_d;
    logic                  err_q, err_d;
    logic [31:0]           i_hold_q, d_hold_q;

    logic                  force_i;
    logic                  i_gnt, d_gnt, grant;
    logic                  misaligned;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] sel_word;
    logic                  i_rvalid, d_rvalid;
    logic [31:0]           i_rdata, d_rdata;

    always_comb begin
        force_i  = (stall_cnt_q == 4'(MAX_STALL));
        d_gnt    = ready_q & bus.d_req & ~force_i;
        i_gnt    = ready_q & bus.i_req & (~bus.d_req | force_i);
        grant    = i_gnt | d_gnt;
        sel_word = d_gnt ? bus.d_addr[ADDR_WIDTH+1:2] : bus.i_addr[ADDR_WIDTH+1:2];
`ifdef IMEM_ARB_MISALIGN_CHK_EN
        misaligned = (d_gnt & (bus.d_addr[1:0] != 2'b00)) |
                     (i_gnt & (bus.i_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        mem_en = grant & ~misaligned;
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_addr  = mem_en ? sel_word : '0;
    assign bus.mem_we    = (mem_en & d_gnt & bus.d_we) ? bus.d_be : '0;
    assign bus.mem_wdata = mem_en ? bus.d_wdata : '0;

    always_comb begin
        owner_d = OWN_NONE;
        if (i_gnt) begin
            owner_d = OWN_I;
        end else if (d_gnt) begin
            owner_d = bus.d_we ? OWN_DWR : OWN_DRD;
        end
        err_d = misaligned;
    end

    // Counter saturates at MAX_STALL; the forced I grant itself clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!bus.i_req || i_gnt) begin
            stall_cnt_d = '0;
        end else if (ready_q && !force_i) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            stall_cnt_q <= '0;
            owner_q     <= OWN_NONE;
            err_q       <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            stall_cnt_q <= stall_cnt_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
        end
    end

    // RAM data is only present in the response cycle, so rdata passes it through
    // then and replays the captured copy afterwards.
    always_comb begin
        i_rvalid = (owner_q == OWN_I);
        d_rvalid = (owner_q == OWN_DRD) || (owner_q == OWN_DWR);
        i_rdata  = i_hold_q;
        d_rdata  = d_hold_q;
        if (i_rvalid) begin
            i_rdata = err_q ? '0 : bus.mem_rdata;
        end
        if (d_rvalid) begin
            d_rdata = (err_q || owner_q == OWN_DWR) ? '0 : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            if (i_rvalid) i_hold_q <= i_rdata;
            if (d_rvalid) d_hold_q <= d_rdata;
        end
    end

    assign bus.i_rvalid = i_rvalid;
    assign bus.d_rvalid = d_rvalid;
    assign bus.i_rdata  = i_rdata;
    assign bus.d_rdata  = d_rdata;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    assign bus.i_err    = i_rvalid & err_q;
    assign bus.d_err    = d_rvalid & err_q;
`else
    assign bus.i_err    = 1'b0;
    assign bus.d_err    = 1'b0;
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus queues expected responses, a monitor checks them.
// Runs with or without IMEM_ARB_MISALIGN_CHK_EN.
module tb_imem_arbiter;
    localparam int AW = 12;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [32:0] i_q[$];
    logic [32:0] d_q[$];

    imem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    imem_arbiter #(.ADDR_WIDTH(AW), .MAX_STALL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word k initialised to A500_0000 + k, 1-cycle read latency.
    initial begin
        logic [31:0] ram [1 << AW];
        for (int k = 0; k < (1 << AW); k++) ram[k] = 32'hA500_0000 + k;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end else begin
                    bus.mem_rdata <= ram[bus.mem_addr];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.i_gnt && bus.d_gnt) begin
            fails++;
            $display("FAIL both_gnt: i_gnt and d_gnt both 1 at %0t", $time);
        end
        if (bus.i_rvalid) begin
            if (i_q.size() == 0) begin
                fails++;
                $display("FAIL i_unexpected: i_rvalid with no expected response at %0t", $time);
            end else begin
                e = i_q.pop_front();
                chk("i_rdata", bus.i_rdata, e[31:0]);
                chk("i_err", 32'(bus.i_err), 32'(e[32]));
            end
        end
        if (bus.d_rvalid) begin
            if (d_q.size() == 0) begin
                fails++;
                $display("FAIL d_unexpected: d_rvalid with no expected response at %0t", $time);
            end else begin
                e = d_q.pop_front();
                chk("d_rdata", bus.d_rdata, e[31:0]);
                chk("d_err", 32'(bus.d_err), 32'(e[32]));
            end
        end
    end

    task automatic do_i(input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input logic exp_en, input int exp_wait);
        int waited = 0;
        bit got = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.i_gnt) begin
                got = 1;
                break;
            end
            waited++;
        end
        if (!got) begin
            fails++;
            $display("FAIL i_gnt_timeout: no grant for addr %h", addr);
            bus.i_req = 1'b0;
            return;
        end
        chk("i_wait", 32'(waited), 32'(exp_wait));
        chk("i_mem_en", 32'(bus.mem_en), 32'(exp_en));
        if (exp_en) chk("i_mem_addr", 32'(bus.mem_addr), 32'(addr[AW+1:2]));
        i_q.push_back({exp_err, exp_data});
        @(posedge clk);
        #1 bus.i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_err, input logic exp_en, input int exp_wait);
        int waited = 0;
        bit got = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_be    = be;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.d_gnt) begin
                got = 1;
                break;
            end
            waited++;
        end
        if (!got) begin
            fails++;
            $display("FAIL d_gnt_timeout: no grant for addr %h", addr);
            bus.d_req = 1'b0;
            return;
        end
        chk("d_wait", 32'(waited), 32'(exp_wait));
        chk("d_mem_en", 32'(bus.mem_en), 32'(exp_en));
        if (exp_en) begin
            chk("d_mem_addr", 32'(bus.mem_addr), 32'(addr[AW+1:2]));
            chk("d_mem_we", 32'(bus.mem_we), we ? 32'(be) : 32'd0);
        end
        d_q.push_back({exp_err, exp_data});
        @(posedge clk);
        #1 bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.i_req = 1'b1;   bus.i_addr = 32'h0;
        bus.d_req = 1'b0;   bus.d_we = 1'b0;  bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_errs", 32'({bus.i_err, bus.d_err}), 32'd0);
        chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);

        // Release: no grant until ready is set on the next edge
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_i_gnt", 32'(bus.i_gnt), 32'd0);
        chk("release_mem_en", 32'(bus.mem_en), 32'd0);
        do_i(32'h0, 32'hA500_0000, 1'b0, 1'b1, 0);

        // Pipelined fetch of words 0..3
        do_i(32'h0, 32'hA500_0000, 1'b0, 1'b1, 0);
        do_i(32'h4, 32'hA500_0001, 1'b0, 1'b1, 0);
        do_i(32'h8, 32'hA500_0002, 1'b0, 1'b1, 0);
        do_i(32'hC, 32'hA500_0003, 1'b0, 1'b1, 0);

        // Address wrap modulo RAM size
        do_i(32'h4000, 32'hA500_0000, 1'b0, 1'b1, 0);

        // D priority with starvation guard: D,D,D,D,I repeating
        @(posedge clk);
        #1;
        bus.i_req = 1'b1;  bus.i_addr = 32'h0;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h10;
        for (int k = 0; k < 10; k++) begin
            exp_d = (k % 5) != 4;
            @(negedge clk);
            chk("prio_d_gnt", 32'(bus.d_gnt), 32'(exp_d));
            chk("prio_i_gnt", 32'(bus.i_gnt), 32'(!exp_d));
            if (exp_d) d_q.push_back({1'b0, 32'hA500_0004});
            else       i_q.push_back({1'b0, 32'hA500_0000});
            @(posedge clk);
            #1;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;

        // Misalignment: read 0x22, fetch 0x5, write 0x26 then read back word 9
`ifdef IMEM_ARB_MISALIGN_CHK_EN
        do_d(1'b0, 4'h0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        do_i(32'h5, 32'h0, 1'b1, 1'b0, 0);
        do_d(1'b1, 4'hF, 32'h26, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 0);
        do_d(1'b0, 4'h0, 32'h24, 32'h0, 32'hA500_0009, 1'b0, 1'b1, 0);
`else
        do_d(1'b0, 4'h0, 32'h22, 32'h0, 32'hA500_0008, 1'b0, 1'b1, 0);
        do_i(32'h5, 32'hA500_0001, 1'b0, 1'b1, 0);
        do_d(1'b1, 4'hF, 32'h26, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 0);
        do_d(1'b0, 4'h0, 32'h24, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 0);
`endif

        // Write, byte-masked write, back-to-back read of the same word
        do_d(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 0);
        do_d(1'b1, 4'h1, 32'h20, 32'h0000_00AA, 32'h0, 1'b0, 1'b1, 0);
        do_d(1'b0, 4'h0, 32'h20, 32'h0, 32'hDEAD_BEAA, 1'b0, 1'b1, 0);

        // Reset with a read response pending: response is dropped
        @(posedge clk);
        #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        @(negedge clk);
        chk("midrst_d_gnt", 32'(bus.d_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("midrst_d_rdata", bus.d_rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_i(32'h8, 32'hA500_0002, 1'b0, 1'b1, 0);

        repeat (3) @(negedge clk);
        chk("i_q_empty", 32'(i_q.size()), 32'd0);
        chk("d_q_empty", 32'(d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
